// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture
// Description : Measures high time and period of an asynchronous PWM input
//               in clk_i cycles, with timeout, one-shot/continuous modes and
//               a small register interface.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        write,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic        pwm_i,
    output logic        irq_o
);

    localparam logic [7:0] c_addr_ctrl    = 8'h00;
    localparam logic [7:0] c_addr_status  = 8'h04;
    localparam logic [7:0] c_addr_high    = 8'h08;
    localparam logic [7:0] c_addr_period  = 8'h0C;
    localparam logic [7:0] c_addr_timeout = 8'h10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_sync1, r_sync2, r_dly;
    logic [31:0] r_cnt, w_cnt_nxt;
    logic [31:0] r_high_tmp, w_high_tmp_nxt;
    logic [2:0]  r_ctrl;
    logic        r_valid, r_ovf;
    logic [31:0] r_high, r_period, r_timeout;

    logic        w_rise, w_fall;
    logic        w_wr_ctrl, w_wr_status, w_wr_timeout, w_disable;
    logic [31:0] w_timeout_eff, w_cnt_inc;
    logic        w_expired, w_capture, w_ovf_set;

    assign w_rise = r_sync2 & ~r_dly;
    assign w_fall = ~r_sync2 & r_dly;

    assign w_wr_ctrl    = write && (addr_i == c_addr_ctrl);
    assign w_wr_status  = write && (addr_i == c_addr_status);
    assign w_wr_timeout = write && (addr_i == c_addr_timeout);
    assign w_disable    = w_wr_ctrl && !wdata_i[0];

    assign w_timeout_eff = (r_timeout == 32'd0) ? 32'd1 : r_timeout;
    assign w_cnt_inc     = (&r_cnt) ? r_cnt : r_cnt + 32'd1;
    // >= rather than == so a TIMEOUT lowered below a running count still fires
    assign w_expired     = (r_cnt >= w_timeout_eff);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_dly   <= 1'b0;
        end else begin
            r_sync1 <= pwm_i;
            r_sync2 <= r_sync1;
            r_dly   <= r_sync2;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 32'd0;
            r_high_tmp <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_high_tmp <= w_high_tmp_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_high_tmp_nxt = r_high_tmp;
        w_capture      = 1'b0;
        w_ovf_set      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = 32'd0;
                if (r_ctrl[0]) w_state_nxt = ST_ARM;
            end
            ST_ARM: begin
                if (w_rise) begin
                    w_cnt_nxt   = 32'd1;
                    w_state_nxt = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (w_fall) begin
                    w_high_tmp_nxt = r_cnt;
                    w_cnt_nxt      = w_cnt_inc;
                    w_state_nxt    = ST_LOW;
                end else if (w_expired) begin
                    w_ovf_set   = 1'b1;
                    w_cnt_nxt   = 32'd0;
                    w_state_nxt = ST_ARM;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_LOW: begin
                if (w_rise) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = r_ctrl[1] ? 32'd1 : 32'd0;
                    w_state_nxt = r_ctrl[1] ? ST_HIGH : ST_IDLE;
                end else if (w_expired) begin
                    w_ovf_set   = 1'b1;
                    w_cnt_nxt   = 32'd0;
                    w_state_nxt = ST_ARM;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Software disable discards whatever the FSM was about to record
        if (w_disable) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 32'd0;
            w_capture   = 1'b0;
            w_ovf_set   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ctrl    <= 3'd0;
            r_valid   <= 1'b0;
            r_ovf     <= 1'b0;
            r_high    <= 32'd0;
            r_period  <= 32'd0;
            r_timeout <= 32'hFFFF_FFFF;
        end else begin
            if (w_wr_ctrl)
                r_ctrl <= wdata_i[2:0];
            else if (w_capture && !r_ctrl[1])
                r_ctrl[0] <= 1'b0;
            r_valid <= w_capture | (r_valid & ~(w_wr_status & wdata_i[0]));
            r_ovf   <= w_ovf_set | (r_ovf & ~(w_wr_status & wdata_i[1]));
            if (w_capture) begin
                r_high   <= r_high_tmp;
                r_period <= r_cnt;
            end
            if (w_wr_timeout)
                r_timeout <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = 32'd0;
        case (addr_i)
            c_addr_ctrl:    rdata_o = {29'd0, r_ctrl};
            c_addr_status:  rdata_o = {29'd0, (r_state != ST_IDLE), r_ovf, r_valid};
            c_addr_high:    rdata_o = r_high;
            c_addr_period:  rdata_o = r_period;
            c_addr_timeout: rdata_o = r_timeout;
            default:        rdata_o = 32'd0;
        endcase
    end

    assign irq_o = r_ctrl[2] & (r_valid | r_ovf);

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_capture
// Description : Self-checking bench for pwm_capture with a cycle-level
//               waveform model of expected HIGH/PERIOD/flag values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;

    localparam int SYNC_LAT = 3;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        write = 1'b0;
    logic [7:0]  addr_i = 8'h00;
    logic [31:0] wdata_i = 32'd0;
    logic [31:0] rdata_o;
    logic        pwm_i = 1'b0;
    logic        irq_o;

    int          total = 0;
    int          bad = 0;
    logic [31:0] d;

    pwm_capture dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .write   (write),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o),
        .pwm_i   (pwm_i),
        .irq_o   (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick(input logic p);
        @(negedge clk_i);
        write = 1'b0;
        pwm_i = p;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] v);
        write   = 1'b1;
        addr_i  = a;
        wdata_i = v;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] v);
        addr_i = a;
        #1;
        v = rdata_o;
    endtask

    task automatic wave(input int h, input int l);
        repeat (h) tick(1'b1);
        repeat (l) tick(1'b0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        repeat (3) tick(1'b0);
        rst_ni = 1'b1;
        tick(1'b0);
    endtask

    task automatic test_reset();
        logic [31:0] exp_rd [6];
        logic [7:0]  addrs  [6];
        exp_rd = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0};
        addrs  = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            rd(addrs[i], d);
            total++;
            if (d !== exp_rd[i]) begin
                bad++;
                $display("FAIL reset_read[%0h] got=%h want=%h", addrs[i], d, exp_rd[i]);
            end
        end
        total++;
        if (irq_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_irq got=%b want=0", irq_o);
        end
        // Reset in the middle of a measurement
        wr(8'h00, 32'h7);
        repeat (4) tick(1'b0);
        repeat (5) tick(1'b1);
        #2 rst_ni = 1'b0;
        rd(8'h00, d);
        total++;
        if (d !== 32'd0 || irq_o !== 1'b0) begin
            bad++;
            $display("FAIL async_reset ctrl=%h irq=%b want 0/0", d, irq_o);
        end
        tick(1'b1);
        rst_ni = 1'b1;
        wave(3, 3);
        wave(3, 3);
        rd(8'h04, d);
        total++;
        if (d !== 32'd0) begin
            bad++;
            $display("FAIL post_reset_idle status got=%h want=0", d);
        end
    endtask

    task automatic test_continuous();
        do_reset();
        wr(8'h00, 32'h7);
        repeat (4) tick(1'b0);
        repeat (3) wave(6, 4);
        repeat (4) tick(1'b1);
        rd(8'h08, d);
        total++;
        if (d !== 32'd6) begin bad++; $display("FAIL cont_high got=%0d want=6", d); end
        rd(8'h0C, d);
        total++;
        if (d !== 32'd10) begin bad++; $display("FAIL cont_period got=%0d want=10", d); end
        rd(8'h04, d);
        total++;
        if (d[0] !== 1'b1 || irq_o !== 1'b1) begin
            bad++;
            $display("FAIL cont_valid status=%h irq=%b want valid=1 irq=1", d, irq_o);
        end
        wr(8'h04, 32'h1);
        tick(1'b1);
        rd(8'h04, d);
        total++;
        if (d !== 32'h4 || irq_o !== 1'b0) begin
            bad++;
            $display("FAIL cont_w1c status=%h irq=%b want 4/0", d, irq_o);
        end
        tick(1'b1);
        repeat (4) tick(1'b0);
        repeat (4) tick(1'b1);
        rd(8'h04, d);
        total++;
        if (d[0] !== 1'b1 || irq_o !== 1'b1) begin
            bad++;
            $display("FAIL cont_reset_valid status=%h irq=%b want valid=1 irq=1", d, irq_o);
        end
    endtask

    task automatic test_oneshot();
        do_reset();
        wr(8'h00, 32'h1);
        repeat (4) tick(1'b0);
        wave(3, 7);
        wave(3, 7);
        repeat (4) tick(1'b1);
        rd(8'h00, d);
        total++;
        if (d !== 32'd0) begin bad++; $display("FAIL oneshot_ctrl got=%h want=0", d); end
        rd(8'h04, d);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL oneshot_status got=%h want=1", d); end
        tick(1'b0);
        repeat (3) wave(5, 4);
        rd(8'h08, d);
        total++;
        if (d !== 32'd3) begin bad++; $display("FAIL oneshot_high got=%0d want=3", d); end
        rd(8'h0C, d);
        total++;
        if (d !== 32'd10) begin bad++; $display("FAIL oneshot_period got=%0d want=10", d); end
    endtask

    task automatic timeout_case(input int tval, input string name);
        int eff;
        int ovf_edge;
        eff      = (tval == 0) ? 1 : tval;
        ovf_edge = SYNC_LAT + eff;
        do_reset();
        wr(8'h10, tval);
        tick(1'b0);
        wr(8'h00, 32'h5);
        repeat (4) tick(1'b0);
        tick(1'b1);
        repeat (ovf_edge - 1) tick(1'b1);
        rd(8'h04, d);
        total++;
        if (d[1] !== 1'b0) begin bad++; $display("FAIL %s_early status=%h want ovf=0", name, d); end
        tick(1'b1);
        rd(8'h04, d);
        total++;
        if (d !== 32'h6 || irq_o !== 1'b1) begin
            bad++;
            $display("FAIL %s_ovf status=%h irq=%b want 6/1", name, d, irq_o);
        end
        repeat (5) tick(1'b1);
        rd(8'h08, d);
        total++;
        if (d !== 32'd0) begin bad++; $display("FAIL %s_high got=%0d want=0", name, d); end
        rd(8'h0C, d);
        total++;
        if (d !== 32'd0) begin bad++; $display("FAIL %s_period got=%0d want=0", name, d); end
    endtask

    task automatic test_timeout();
        timeout_case(20, "timeout20");
        timeout_case(0, "timeout0");
        // Period exactly equal to TIMEOUT: the rise edge must win
        do_reset();
        wr(8'h10, 32'd12);
        tick(1'b0);
        wr(8'h00, 32'h1);
        repeat (4) tick(1'b0);
        wave(4, 8);
        wave(4, 8);
        rd(8'h04, d);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL edge_wins status=%h want=1", d); end
        rd(8'h0C, d);
        total++;
        if (d !== 32'd12) begin bad++; $display("FAIL edge_wins_period got=%0d want=12", d); end
    endtask

    task automatic test_disable();
        do_reset();
        wr(8'h00, 32'h3);
        repeat (4) tick(1'b0);
        wave(6, 4);
        wave(6, 4);
        repeat (5) tick(1'b1);
        wr(8'h00, 32'h0);
        tick(1'b1);
        rd(8'h04, d);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL disable_status got=%h want=1", d); end
        rd(8'h08, d);
        total++;
        if (d !== 32'd6) begin bad++; $display("FAIL disable_high got=%0d want=6", d); end
        repeat (6) tick(1'b0);
        wr(8'h00, 32'h3);
        repeat (4) tick(1'b0);
        wave(5, 5);
        // Re-writing EN=1 mid-period must not restart the measurement
        repeat (2) tick(1'b1);
        wr(8'h00, 32'h3);
        repeat (3) tick(1'b1);
        repeat (5) tick(1'b0);
        repeat (4) tick(1'b1);
        rd(8'h08, d);
        total++;
        if (d !== 32'd5) begin bad++; $display("FAIL reenable_high got=%0d want=5", d); end
        rd(8'h0C, d);
        total++;
        if (d !== 32'd10) begin bad++; $display("FAIL reenable_period got=%0d want=10", d); end
    endtask

    task automatic test_w1c_race();
        do_reset();
        wr(8'h00, 32'h3);
        repeat (4) tick(1'b0);
        wave(4, 4);
        repeat (SYNC_LAT) tick(1'b1);
        wr(8'h04, 32'h1);
        tick(1'b1);
        rd(8'h04, d);
        total++;
        if (d[0] !== 1'b1) begin bad++; $display("FAIL w1c_race status=%h want valid=1", d); end
        rd(8'h0C, d);
        total++;
        if (d !== 32'd8) begin bad++; $display("FAIL w1c_race_period got=%0d want=8", d); end
        wr(8'h04, 32'h1);
        tick(1'b1);
        rd(8'h04, d);
        total++;
        if (d[0] !== 1'b0) begin bad++; $display("FAIL w1c_plain status=%h want valid=0", d); end
    endtask

    task automatic test_random();
        int hq[$];
        int lq[$];
        int n;
        n = 10;
        for (int i = 0; i < n; i++) begin
            hq.push_back($urandom_range(2, 12));
            lq.push_back($urandom_range(2, 12));
        end
        do_reset();
        wr(8'h00, 32'h7);
        repeat (4) tick(1'b0);
        for (int i = 0; i < n; i++) begin
            wave(hq[i], lq[i]);
            if (i > 0) begin
                rd(8'h08, d);
                total++;
                if (d !== hq[i-1]) begin
                    bad++;
                    $display("FAIL rand_high[%0d] got=%0d want=%0d", i, d, hq[i-1]);
                end
                rd(8'h0C, d);
                total++;
                if (d !== hq[i-1] + lq[i-1]) begin
                    bad++;
                    $display("FAIL rand_period[%0d] got=%0d want=%0d", i, d, hq[i-1] + lq[i-1]);
                end
                total++;
                if (irq_o !== 1'b1) begin
                    bad++;
                    $display("FAIL rand_irq[%0d] got=%b want=1", i, irq_o);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_oneshot();
        test_timeout();
        test_disable();
        test_w1c_race();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
